// File: rtl/mc_issue_pkg.sv
// mc_issue_pkg: shared encodings for the multi-cycle op issuer and its unit bank.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mc_issue_pkg;

   localparam int MC_DW = 32;

   // Issuer FSM encoding, kept as plain constants so older code can compare against them
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_WB     = 2'd3;

   typedef enum logic [1:0] {
      OP_CLZ = 2'd0,
      OP_MUL = 2'd1,
      OP_DIV = 2'd2,
      OP_RSV = 2'd3
   } mc_op_e;

   // Request fields that must survive until write-back
   typedef struct packed {
      logic [1:0] op;
      logic [4:0] rd;
   } req_tag_t;

   // True when the op code addresses a unit that is actually attached
   function automatic logic op_in_range(input logic [1:0] op, input int num_units);
      return int'(op) < num_units;
   endfunction

endpackage

// File: rtl/mc_op_issuer_if.sv
// mc_op_issuer_if: request, unit-bank and write-back signals of the multi-cycle issuer.
// Latency: none (wiring only).
// Backpressure: stall holds the requester; units hold the issuer through unit_busy.
interface mc_op_issuer_if
   import mc_issue_pkg::*;
#(
   parameter int NUM_UNITS = 4,
   parameter int DW        = MC_DW
);
   logic                    req_valid;
   logic [1:0]              req_op;
   logic [DW-1:0]           req_a;
   logic [DW-1:0]           req_b;
   logic [4:0]              req_rd;
   logic                    stall;
   logic [NUM_UNITS-1:0]    unit_start;
   logic [DW-1:0]           unit_a;
   logic [DW-1:0]           unit_b;
   logic [NUM_UNITS-1:0]    unit_busy;
   logic [NUM_UNITS*DW-1:0] unit_result;
   logic                    wb_en;
   logic [4:0]              wb_addr;
   logic [DW-1:0]           wb_data;
   logic                    err_timeout;

   // Issuer side
   modport master (
      input  req_valid, req_op, req_a, req_b, req_rd, unit_busy, unit_result,
      output stall, unit_start, unit_a, unit_b, wb_en, wb_addr, wb_data, err_timeout
   );

   // CPU control plus unit bank side
   modport slave (
      output req_valid, req_op, req_a, req_b, req_rd, unit_busy, unit_result,
      input  stall, unit_start, unit_a, unit_b, wb_en, wb_addr, wb_data, err_timeout
   );
endinterface

// File: rtl/mc_op_issuer.sv
// mc_op_issuer: issues one multi-cycle op to an iterative unit via start/busy and writes the result back.
// Latency: req -> wb_en is 3 + busy cycles (1 cycle for an out-of-range op); optional MC_ISSUE_TIMEOUT_EN watchdog.
// Backpressure: stall is high whenever not IDLE; req_valid is only sampled in IDLE.
module mc_op_issuer
   import mc_issue_pkg::*;
#(
   parameter int NUM_UNITS      = 4,
   parameter int DW             = MC_DW,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic            clk,
   input logic            rst_n,
   mc_op_issuer_if.master bus
);

   logic [1:0]    state_q;
   req_tag_t      tag_q;
   logic [DW-1:0] a_q;
   logic [DW-1:0] b_q;
   logic [DW-1:0] res_q;
   logic [DW-1:0] res_arr [NUM_UNITS];
   logic [DW-1:0] sel_result;
   logic          sel_busy;
   logic          timeout_hit;

   // Per-unit result slices and the one-hot start pulse for the latched op
   for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unit
      assign res_arr[k]        = bus.unit_result[k*DW +: DW];
      assign bus.unit_start[k] = (state_q == ST_LAUNCH) && (int'(tag_q.op) == k);
   end

   // Select the busy bit and result of the unit this request was sent to
   always_comb begin
      sel_result = '0;
      sel_busy   = 1'b0;
      for (int k = 0; k < NUM_UNITS; k++) begin
         if (int'(tag_q.op) == k) begin
            sel_result = res_arr[k];
            sel_busy   = bus.unit_busy[k];
         end
      end
   end

`ifdef MC_ISSUE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] wait_cnt_q;
   logic          tmo_q;

   // Last permitted WAIT cycle with the unit still busy
   assign timeout_hit = (state_q == ST_WAIT) && sel_busy &&
                        (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

   // WAIT-cycle counter, restarted for every launched op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else if (state_q == ST_LAUNCH) begin
         wait_cnt_q <= '0;
      end else if (state_q == ST_WAIT) begin
         wait_cnt_q <= wait_cnt_q + CW'(1);
      end
   end

   // Error pulse lines up with the WB cycle that carries the zero result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= 1'b0;
      else        tmo_q <= timeout_hit;
   end

   assign bus.err_timeout = tmo_q;
`else
   assign timeout_hit     = 1'b0;
   // Constant 0; a negative limit is impossible, so this only anchors the unused parameter
   assign bus.err_timeout = (TIMEOUT_CYCLES < 0);
`endif

   // Issue FSM plus the operand, tag and result registers it owns
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tag_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  tag_q.op <= bus.req_op;
                  tag_q.rd <= bus.req_rd;
                  a_q      <= bus.req_a;
                  b_q      <= bus.req_b;
                  if (op_in_range(bus.req_op, NUM_UNITS)) begin
                     state_q <= ST_LAUNCH;
                  end else begin
                     // No unit behind this op: answer with zero, never pulse start
                     res_q   <= '0;
                     state_q <= ST_WB;
                  end
               end
            end
            ST_LAUNCH: state_q <= ST_WAIT;
            ST_WAIT: begin
               if (timeout_hit) begin
                  res_q   <= '0;
                  state_q <= ST_WB;
               end else if (!sel_busy) begin
                  res_q   <= sel_result;
                  state_q <= ST_WB;
               end
            end
            ST_WB:   state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.stall   = (state_q != ST_IDLE);
   assign bus.unit_a  = a_q;
   assign bus.unit_b  = b_q;
   assign bus.wb_en   = (state_q == ST_WB) && (tag_q.rd != 5'd0);
   assign bus.wb_addr = tag_q.rd;
   assign bus.wb_data = res_q;

endmodule

// File: tb/tb_mc_op_issuer.sv
// tb_mc_op_issuer: randomized bench for mc_op_issuer with behavioural CLZ/MUL/DIV units.
// Latency: expected write-back cycle derived from each unit's busy length.
// Backpressure: requester holds req_valid (with junk payload) while stall is high.
module tb_mc_op_issuer;
   import mc_issue_pkg::*;

   localparam int NU  = 3;
   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n;
   bit   stuck;
   int   n_checks = 0;
   int   n_fail   = 0;

   mc_op_issuer_if #(.NUM_UNITS(NU), .DW(32)) bus_if ();

   mc_op_issuer #(.NUM_UNITS(NU), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   function automatic int clz32(input logic [31:0] v);
      for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
      return 32;
   endfunction

   function automatic logic [31:0] unit_res(input int k, input logic [31:0] a, input logic [31:0] b);
      case (k)
         0:       return 32'(clz32(a));
         1:       return a * b;
         default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      endcase
   endfunction

   function automatic int unit_lat(input int k, input logic [31:0] a, input logic [31:0] b);
      case (k)
         0:       return (clz32(a) == 0) ? 1 : clz32(a);
         1:       return 2 + int'(a % 32'd5);
         default: return 1 + int'(b % 32'd7);
      endcase
   endfunction

   // Expected outcome of one request, measured in cycles after the accepting edge
   int          e_cyc;
   logic [31:0] e_data;
   int          e_starts;
   int          e_wbs;
   int          e_tmo;

   task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
      int n;
      e_wbs = (rd != 5'd0) ? 1 : 0;
      e_tmo = 0;
      if (int'(op) >= NU) begin
         e_cyc = 1; e_data = '0; e_starts = 0;
      end else begin
         n = unit_lat(int'(op), a, b);
         e_starts = 1;
         e_cyc    = n + 3;
         e_data   = unit_res(int'(op), a, b);
`ifdef MC_ISSUE_TIMEOUT_EN
         if (n >= TMO) begin
            e_cyc = TMO + 2; e_data = '0; e_tmo = 1;
         end
`endif
      end
   endtask

   // Unit bank: selected unit runs its countdown, idle units drive noise on busy/result
   int ph   [NU];
   int left [NU];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NU; k++) begin
            bus_if.unit_busy[k]            <= 1'b0;
            bus_if.unit_result[k*32 +: 32] <= '0;
            ph[k]   <= 0;
            left[k] <= 0;
         end
      end else begin
         for (int k = 0; k < NU; k++) begin
            if (bus_if.unit_start[k]) begin
               ph[k]                          <= 1;
               left[k]                        <= unit_lat(k, bus_if.unit_a, bus_if.unit_b) - 1;
               bus_if.unit_busy[k]            <= 1'b1;
               bus_if.unit_result[k*32 +: 32] <= unit_res(k, bus_if.unit_a, bus_if.unit_b);
            end else if (ph[k] == 1) begin
               if (stuck)            bus_if.unit_busy[k] <= 1'b1;
               else if (left[k] > 0) left[k] <= left[k] - 1;
               else begin
                  bus_if.unit_busy[k] <= 1'b0;
                  ph[k] <= 2;
               end
            end else if (ph[k] == 2) begin
               ph[k] <= 0;
            end else begin
               bus_if.unit_busy[k]            <= 1'(($urandom) & 1);
               bus_if.unit_result[k*32 +: 32] <= $urandom;
            end
         end
      end
   end

   // Observations of one request, filled in by issue()
   bit          o_done;
   int          o_last;
   int          o_starts;
   int          o_start_cyc;
   logic [2:0]  o_start_vec;
   int          o_wbs;
   int          o_wb_cyc;
   int          o_tmo;
   int          o_tmo_cyc;
   int          o_abad;
   logic [4:0]  o_addr;
   logic [31:0] o_data;

   // Present a request in IDLE, then hold req_valid with junk payload until stall drops
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int limit);
      bus_if.req_valid = 1'b1;
      bus_if.req_op = op; bus_if.req_a = a; bus_if.req_b = b; bus_if.req_rd = rd;
      @(posedge clk);
      @(negedge clk);
      bus_if.req_op = 2'($urandom); bus_if.req_a = $urandom;
      bus_if.req_b = $urandom; bus_if.req_rd = 5'($urandom);
      o_done = 0; o_last = 0; o_starts = 0; o_start_cyc = 0; o_start_vec = '0;
      o_wbs = 0; o_wb_cyc = 0; o_tmo = 0; o_tmo_cyc = 0; o_abad = 0;
      o_addr = '0; o_data = '0;
      for (int c = 1; c <= limit; c++) begin
         if (!bus_if.stall) begin
            o_done = 1; o_last = c - 1;
            break;
         end
         if (bus_if.unit_start != '0) begin
            o_starts++; o_start_cyc = c; o_start_vec = bus_if.unit_start;
         end
         if (bus_if.unit_a !== a || bus_if.unit_b !== b) o_abad++;
         if (bus_if.wb_en === 1'b1) begin o_wbs++; o_wb_cyc = c; end
         if (bus_if.err_timeout === 1'b1) begin o_tmo++; o_tmo_cyc = c; end
         o_addr = bus_if.wb_addr;
         o_data = bus_if.wb_data;
         @(negedge clk);
      end
      bus_if.req_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; stuck = 0;
      bus_if.req_valid = 1'b0; bus_if.req_op = '0; bus_if.req_a = '0;
      bus_if.req_b = '0; bus_if.req_rd = '0;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if (bus_if.stall !== 1'b0 || bus_if.unit_start !== 3'b000 || bus_if.wb_en !== 1'b0 ||
          bus_if.err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: stall=%b start=%b wb_en=%b err=%b, want all 0",
                  bus_if.stall, bus_if.unit_start, bus_if.wb_en, bus_if.err_timeout);
      end
      n_checks++;
      if (bus_if.unit_a !== '0 || bus_if.unit_b !== '0 || bus_if.wb_addr !== '0 ||
          bus_if.wb_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: a=%h b=%h addr=%h data=%h, want all 0",
                  bus_if.unit_a, bus_if.unit_b, bus_if.wb_addr, bus_if.wb_data);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clz_min;
      issue(2'd0, 32'h8000_0000, 32'h1234_5678, 5'd3, 100);
      ref_model(2'd0, 32'h8000_0000, 32'h1234_5678, 5'd3);
      n_checks++;
      if (o_starts != 1 || o_start_cyc != 1 || o_start_vec !== 3'b001) begin
         n_fail++;
         $display("FAIL clz_min_start: starts=%0d cyc=%0d vec=%b, want 1 at t1 vec 001",
                  o_starts, o_start_cyc, o_start_vec);
      end
      n_checks++;
      if (o_wbs != 1 || o_wb_cyc != 4 || o_addr !== 5'd3 || o_data !== 32'd0) begin
         n_fail++;
         $display("FAIL clz_min_wb: n=%0d cyc=%0d addr=%0d data=%h, want 1 at t4 addr 3 data 0",
                  o_wbs, o_wb_cyc, o_addr, o_data);
      end
      n_checks++;
      if (!o_done || o_last != 4 || o_last != e_cyc) begin
         n_fail++;
         $display("FAIL clz_min_stall: done=%0d last=%0d, want stall t1..t4", o_done, o_last);
      end
   endtask

   task automatic test_clz_long;
      issue(2'd0, 32'h0000_0001, 32'($urandom), 5'd9, 100);
      ref_model(2'd0, 32'h0000_0001, 32'd0, 5'd9);
      n_checks++;
      if (!o_done || o_wb_cyc != e_cyc || o_data !== e_data || o_tmo != e_tmo) begin
         n_fail++;
         $display("FAIL clz_long_wb: cyc=%0d data=%0d tmo=%0d, want cyc=%0d data=%0d tmo=%0d",
                  o_wb_cyc, o_data, o_tmo, e_cyc, e_data, e_tmo);
      end
      n_checks++;
      if (o_abad != 0) begin
         n_fail++;
         $display("FAIL clz_long_hold: operand drift cycles=%0d, want 0", o_abad);
      end
   endtask

   task automatic test_invalid_op;
      issue(2'd3, 32'($urandom), 32'($urandom), 5'd17, 50);
      n_checks++;
      if (o_starts != 0) begin
         n_fail++;
         $display("FAIL invalid_start: starts=%0d vec=%b, want 0", o_starts, o_start_vec);
      end
      n_checks++;
      if (!o_done || o_wbs != 1 || o_wb_cyc != 1 || o_last != 1 || o_data !== 32'd0 ||
          o_addr !== 5'd17) begin
         n_fail++;
         $display("FAIL invalid_wb: n=%0d cyc=%0d last=%0d addr=%0d data=%h, want 1 at t1 addr 17 data 0",
                  o_wbs, o_wb_cyc, o_last, o_addr, o_data);
      end
   endtask

   task automatic test_rd_zero;
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      issue(2'd1, a, b, 5'd0, 100);
      ref_model(2'd1, a, b, 5'd0);
      n_checks++;
      if (o_wbs != 0 || !o_done || o_last != e_cyc || o_starts != 1) begin
         n_fail++;
         $display("FAIL rd_zero: wbs=%0d done=%0d last=%0d starts=%0d, want 0/1/%0d/1",
                  o_wbs, o_done, o_last, o_starts, e_cyc);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom_range(0, 3));
         a  = (op == 2'd0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
         rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         ref_model(op, a, b, rd);
         issue(op, a, b, rd, 100);
         n_checks++;
         if (!o_done || o_last != e_cyc || o_wbs != e_wbs || (e_wbs == 1 && o_wb_cyc != e_cyc)) begin
            n_fail++;
            $display("FAIL b2b_timing[%0d]: op=%0d done=%0d last=%0d wbs=%0d wbcyc=%0d, want last=%0d wbs=%0d",
                     t, op, o_done, o_last, o_wbs, o_wb_cyc, e_cyc, e_wbs);
         end
         n_checks++;
         if (o_data !== e_data || o_addr !== rd) begin
            n_fail++;
            $display("FAIL b2b_data[%0d]: op=%0d a=%h b=%h data=%h addr=%0d, want data=%h addr=%0d",
                     t, op, a, b, o_data, o_addr, e_data, rd);
         end
         n_checks++;
         if (o_starts != e_starts || (e_starts == 1 && (o_start_cyc != 1 ||
             o_start_vec !== 3'(1 << op))) || o_abad != 0 || o_tmo != e_tmo) begin
            n_fail++;
            $display("FAIL b2b_start[%0d]: op=%0d starts=%0d cyc=%0d vec=%b drift=%0d tmo=%0d, want starts=%0d tmo=%0d",
                     t, op, o_starts, o_start_cyc, o_start_vec, o_abad, o_tmo, e_starts, e_tmo);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] a, b;
      @(negedge clk);
      bus_if.req_valid = 1'b1; bus_if.req_op = 2'd0;
      bus_if.req_a = 32'h0000_0001; bus_if.req_b = 32'hAAAA_5555; bus_if.req_rd = 5'd7;
      @(posedge clk);
      @(negedge clk);
      bus_if.req_valid = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus_if.stall !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_pre: stall=%b, want 1 while waiting", bus_if.stall);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus_if.stall !== 1'b0 || bus_if.unit_start !== 3'b000 || bus_if.wb_en !== 1'b0 ||
          bus_if.unit_a !== '0 || bus_if.wb_data !== '0 || bus_if.wb_addr !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_async: stall=%b start=%b wb_en=%b a=%h data=%h addr=%0d, want all 0",
                  bus_if.stall, bus_if.unit_start, bus_if.wb_en, bus_if.unit_a,
                  bus_if.wb_data, bus_if.wb_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a = $urandom; b = ($urandom >> 20) + 32'd1;
      ref_model(2'd2, a, b, 5'd21);
      issue(2'd2, a, b, 5'd21, 100);
      n_checks++;
      if (!o_done || o_wb_cyc != e_cyc || o_data !== e_data || o_addr !== 5'd21) begin
         n_fail++;
         $display("FAIL rst_mid_recover: cyc=%0d data=%h addr=%0d, want cyc=%0d data=%h addr=21",
                  o_wb_cyc, o_data, o_addr, e_cyc, e_data);
      end
   endtask

   task automatic test_timeout;
      stuck = 1;
      issue(2'd1, 32'd5, 32'd6, 5'd12, 150);
`ifdef MC_ISSUE_TIMEOUT_EN
      n_checks++;
      if (!o_done || o_wbs != 1 || o_wb_cyc != TMO + 2 || o_data !== 32'd0) begin
         n_fail++;
         $display("FAIL timeout_wb: done=%0d wbs=%0d cyc=%0d data=%h, want 1 at t%0d data 0",
                  o_done, o_wbs, o_wb_cyc, o_data, TMO + 2);
      end
      n_checks++;
      if (o_tmo != 1 || o_tmo_cyc != TMO + 2) begin
         n_fail++;
         $display("FAIL timeout_err: pulses=%0d cyc=%0d, want 1 at t%0d", o_tmo, o_tmo_cyc, TMO + 2);
      end
`else
      n_checks++;
      if (o_done || o_wbs != 0 || o_tmo != 0) begin
         n_fail++;
         $display("FAIL timeout_hold: done=%0d wbs=%0d err=%0d, want stall held, no wb, no err",
                  o_done, o_wbs, o_tmo);
      end
`endif
      #2 rst_n = 1'b0;
      stuck = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ref_model(2'd0, 32'h0010_0000, 32'd0, 5'd30);
      issue(2'd0, 32'h0010_0000, 32'd0, 5'd30, 100);
      n_checks++;
      if (!o_done || o_wb_cyc != e_cyc || o_data !== e_data) begin
         n_fail++;
         $display("FAIL timeout_recover: cyc=%0d data=%0d, want cyc=%0d data=%0d",
                  o_wb_cyc, o_data, e_cyc, e_data);
      end
   endtask

   initial begin
      test_reset();
      test_clz_min();
      test_clz_long();
      test_invalid_op();
      test_rd_zero();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
